stream_fifo_buffer: RTL
=======================

// Module: stream_fifo_buffer
// PURPOSE
//  Single-clock, parametrised successor of the SRAM stream FIFO. Buffers words from an upstream
//  first-word-fall-through FIFO in internal block RAM and emits software-requested bursts on a
//  valid/ready stream port. Replaces the fixed 16-bit/SRAM/DCM datapath with a generic buffer.
//  Reports the fill level coherently over the 8-bit register bus.
// PARAMETERS
//  ABUSWIDTH   16  register bus address width
//  DATA_WIDTH  16  word width, 8..32
//  ADDR_WIDTH  10  RAM address bits; DEPTH = 2**ADDR_WIDTH words
// PORTS
//  BUS_CLK             in   1           single clock for all logic
//  RST                 in   1           synchronous, active-high reset
//  BUS_ADD             in   ABUSWIDTH   register address
//  BUS_DATA_IN         in   8           register write data
//  BUS_DATA_OUT        out  8           register read data, registered
//  BUS_WR / BUS_RD     in   1           register write / read strobes
//  FIFO_DATA           in   DATA_WIDTH  upstream word, valid while !FIFO_EMPTY_IN
//  FIFO_EMPTY_IN       in   1           upstream empty
//  FIFO_READ_NEXT_OUT  out  1           upstream pop, combinational
//  STREAM_DATA         out  DATA_WIDTH  output word
//  STREAM_VALID        out  1           output word valid
//  STREAM_READY        in   1           sink accepts; transfer = VALID & READY
// BEHAVIOUR
//  - Internal reset IRST = RST | (BUS_WR & BUS_ADD==0). It clears pointers, level, remaining
//    count, registers, and the overflow counter. All outputs are 0 after reset.
//  - Registers:
//    - 0 R: VERSION=2.
//    - 1..3 RW: READ_COUNT[23:0] in words.
//    - 4 R: LEVEL[7:0]. Reading 4 snapshots LEVEL into a shadow register.
//    - 5, 6 R: snapshot LEVEL[15:8] and [23:16].
//    - 7 R: {5'b0, empty, full, busy}.
//    - 8 R: OVF_CNT (feature). Other addresses read 0.
//  - Write path: FIFO_READ_NEXT_OUT = !FIFO_EMPTY_IN & !full. Each pop stores FIFO_DATA at
//    wr_ptr, and wr_ptr increments modulo DEPTH.
//  - LEVEL: ADDR_WIDTH+1 bits, range 0..DEPTH. full = LEVEL==DEPTH; empty = LEVEL==0.
//    A push and a pop in the same cycle leave LEVEL unchanged.
//  - Start: a BUS_WR to addr 3 while idle, with READ_COUNT!=0, loads remaining=READ_COUNT
//    one cycle later. busy = remaining!=0. A write to 3 while busy updates the register only;
//    the burst in progress is unaffected. A start with READ_COUNT==0 does nothing.
//  - FSM IDLE -> FETCH -> SHOW:
//    - IDLE: wait for busy.
//    - FETCH: wait for !empty. Issue the RAM read at rd_ptr; data lands one cycle later.
//    - SHOW: STREAM_VALID=1 with the word held stable. On READY, rd_ptr++ and remaining--.
//      Return to FETCH if remaining!=0, else to IDLE.
//  - Latency: a start with data already buffered gives STREAM_VALID 3 cycles after the BUS_WR.
//  - Sink stall: VALID and DATA hold while READY=0. VALID never drops without a handshake.
//  - Buffer empty mid-burst: VALID=0 in FETCH until data arrives; the burst then resumes.
//  - Level: the pop decrements LEVEL in the handshake cycle, not at the RAM read.
//  - Wrap-around: pointers wrap DEPTH-1 -> 0 with no gap.
//  - IRST mid-burst: FSM goes to IDLE and VALID drops the next cycle. Buffered data is discarded.
// CONFIGURATION
//  STREAM_FIFO_OVERFLOW_CNT_EN defined:
//    - OVF_CNT[7:0] counts cycles with !FIFO_EMPTY_IN & full. It saturates at 255.
//    - Reading addr 8 returns the count; writing addr 8 clears it.
//  STREAM_FIFO_OVERFLOW_CNT_EN undefined: no counter logic; addr 8 reads 0.
// TESTING
//  1. IRST, then read addr 0/7 -> 0x02 / 0x04 (empty). STREAM_VALID=0, FIFO_READ_NEXT_OUT=0.
//  2. Push 8 words 0x0001..0x0008, READ_COUNT=5, READY=1. Expect:
//     - 5 handshakes with data 0x0001..0x0005;
//     - busy then drops;
//     - LEVEL via addr 4,5,6 = 3.
//  3. DEPTH=16, 16 words pushed. Expect full=1 and FIFO_READ_NEXT_OUT=0 with upstream non-empty.
//     Drain 16 words; then pushes 17..20 wrap and read back in order.
//  4. READ_COUNT=4, 2 words buffered, READY toggled every cycle. Expect:
//     - 2 words out, then VALID=0;
//     - 2 more words pushed, then they stream out;
//     - DATA stable while READY=0.
//  5. Burst of 10 with IRST at handshake 3. Expect VALID=0 next cycle, LEVEL=0, busy=0.
//  6. OVERFLOW_CNT_EN, DEPTH=16, full, upstream non-empty for 300 cycles. Expect:
//     - addr 8 = 0xFF;
//     - a write to addr 8 clears it to 0.

Source files
------------

// File: rtl/stream_fifo_buffer.sv
// stream_fifo_buffer: single-clock stream buffer. Words popped from an upstream
// first-word-fall-through FIFO are stored in an internal RAM. Software-requested
// bursts are emitted on a valid/ready stream port. Fill level, status and burst
// length are reachable over the 8-bit register bus.
// Optional feature: define STREAM_FIFO_OVERFLOW_CNT_EN to add a saturating
// counter at address 8. It counts cycles in which upstream has data but the
// buffer is full.
module stream_fifo_buffer #(
  parameter int ABUSWIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  BUS_CLK,
  input  logic                  RST,
  input  logic [ABUSWIDTH-1:0]  BUS_ADD,
  input  logic [7:0]            BUS_DATA_IN,
  output logic [7:0]            BUS_DATA_OUT,
  input  logic                  BUS_WR,
  input  logic                  BUS_RD,
  input  logic [DATA_WIDTH-1:0] FIFO_DATA,
  input  logic                  FIFO_EMPTY_IN,
  output logic                  FIFO_READ_NEXT_OUT,
  output logic [DATA_WIDTH-1:0] STREAM_DATA,
  output logic                  STREAM_VALID,
  input  logic                  STREAM_READY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [7:0] VERSION = 8'd2;
  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [ABUSWIDTH-1:0] A_RESET  = ABUSWIDTH'(0);
  localparam logic [ABUSWIDTH-1:0] A_CNT0   = ABUSWIDTH'(1);
  localparam logic [ABUSWIDTH-1:0] A_CNT1   = ABUSWIDTH'(2);
  localparam logic [ABUSWIDTH-1:0] A_CNT2   = ABUSWIDTH'(3);
  localparam logic [ABUSWIDTH-1:0] A_LEVEL0 = ABUSWIDTH'(4);
  localparam logic [ABUSWIDTH-1:0] A_LEVEL1 = ABUSWIDTH'(5);
  localparam logic [ABUSWIDTH-1:0] A_LEVEL2 = ABUSWIDTH'(6);
  localparam logic [ABUSWIDTH-1:0] A_STATUS = ABUSWIDTH'(7);
  localparam logic [ABUSWIDTH-1:0] A_OVF    = ABUSWIDTH'(8);

  typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;

  logic                  irst;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic [23:0]           read_count;
  logic [23:0]           remaining;
  logic [23:0]           level_shadow;
  logic                  start_pend;
  logic                  full;
  logic                  empty;
  logic                  busy;
  logic                  push;
  logic                  pop;
  logic                  fetch_rd;
  logic [7:0]            rd_mux;
  state_t                state;
`ifdef STREAM_FIFO_OVERFLOW_CNT_EN
  logic [7:0]            ovf_cnt;
`endif

  // A write to address 0 acts as a soft reset of the whole block.
  assign irst  = RST | (BUS_WR & (BUS_ADD == A_RESET));
  assign full  = (level == LEVEL_FULL);
  assign empty = (level == '0);
  assign busy  = (remaining != 24'd0);

  assign push               = ~FIFO_EMPTY_IN & ~full;
  assign FIFO_READ_NEXT_OUT = push;
  // The word leaves the buffer only when the sink takes it.
  assign pop                = (state == SHOW) & STREAM_READY;
  assign fetch_rd           = (state == FETCH) & ~empty;

  // Buffer RAM write port; contents are not reset.
  always_ff @(posedge BUS_CLK) begin
    if (push) mem[wr_ptr] <= FIFO_DATA;
  end

  // Write pointer and fill level bookkeeping.
  always_ff @(posedge BUS_CLK) begin
    if (irst) begin
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Read data register; it only changes when a new word is fetched, so it
  // stays stable while the sink stalls.
  always_ff @(posedge BUS_CLK) begin
    if (irst)          STREAM_DATA <= '0;
    else if (fetch_rd) STREAM_DATA <= mem[rd_ptr];
  end

  // Burst FSM: fetch one word, present it until handshake, repeat.
  always_ff @(posedge BUS_CLK) begin
    if (irst) begin
      state        <= IDLE;
      STREAM_VALID <= 1'b0;
      rd_ptr       <= '0;
      remaining    <= 24'd0;
    end else begin
      if (start_pend && (read_count != 24'd0)) remaining <= read_count;
      case (state)
        IDLE: begin
          if (busy) state <= FETCH;
        end
        FETCH: begin
          if (!empty) begin
            STREAM_VALID <= 1'b1;
            state        <= SHOW;
          end
        end
        SHOW: begin
          if (STREAM_READY) begin
            STREAM_VALID <= 1'b0;
            rd_ptr       <= rd_ptr + 1'b1;
            remaining    <= remaining - 24'd1;
            state        <= (remaining == 24'd1) ? IDLE : FETCH;
          end
        end
        default: begin
          state        <= IDLE;
          STREAM_VALID <= 1'b0;
        end
      endcase
    end
  end

  // Register read multiplexer.
  always_comb begin
    rd_mux = 8'd0;
    case (BUS_ADD)
      A_RESET:  rd_mux = VERSION;
      A_CNT0:   rd_mux = read_count[7:0];
      A_CNT1:   rd_mux = read_count[15:8];
      A_CNT2:   rd_mux = read_count[23:16];
      A_LEVEL0: rd_mux = 8'(24'(level));
      A_LEVEL1: rd_mux = level_shadow[15:8];
      A_LEVEL2: rd_mux = level_shadow[23:16];
      A_STATUS: rd_mux = {5'b0, empty, full, busy};
`ifdef STREAM_FIFO_OVERFLOW_CNT_EN
      A_OVF:    rd_mux = ovf_cnt;
`endif
      default:  rd_mux = 8'd0;
    endcase
  end

  // Register bus: writes, start request, registered read data and level
  // snapshot (reading the low byte freezes the upper bytes for a coherent read).
  always_ff @(posedge BUS_CLK) begin
    if (irst) begin
      read_count   <= 24'd0;
      level_shadow <= 24'd0;
      start_pend   <= 1'b0;
      BUS_DATA_OUT <= 8'd0;
    end else begin
      start_pend <= BUS_WR && (BUS_ADD == A_CNT2) && !busy && !start_pend;
      if (BUS_WR) begin
        case (BUS_ADD)
          A_CNT0:  read_count[7:0]   <= BUS_DATA_IN;
          A_CNT1:  read_count[15:8]  <= BUS_DATA_IN;
          A_CNT2:  read_count[23:16] <= BUS_DATA_IN;
          default: read_count        <= read_count;
        endcase
      end
      if (BUS_RD) begin
        BUS_DATA_OUT <= rd_mux;
        if (BUS_ADD == A_LEVEL0) level_shadow <= 24'(level);
      end
    end
  end

`ifdef STREAM_FIFO_OVERFLOW_CNT_EN
  // Saturating count of cycles where upstream is blocked by a full buffer.
  always_ff @(posedge BUS_CLK) begin
    if (irst || (BUS_WR && (BUS_ADD == A_OVF))) ovf_cnt <= 8'd0;
    else if (!FIFO_EMPTY_IN && full && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
  end
`endif

endmodule
